// File: rtl/q_sys_pio_pkg.sv
// Shared definitions for the q_sys output PIO with auto-clearing pulse mode:
// register map, timer states and STATUS bit layout.
package q_sys_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_SET       = 3'd4;
  localparam logic [2:0] ADDR_CLEAR     = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;
  localparam logic [2:0] ADDR_COUNT     = 3'd7;

  localparam int STATUS_BUSY_BIT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } timer_state_e;

endpackage

// File: rtl/q_sys_pio_pulse_timer.sv
// Shared down-counter for pulse mode: holds every pulsed bit for max(len,1)
// cycles and raises expire for the single cycle whose edge ends the pulse.
module q_sys_pio_pulse_timer
  import q_sys_pio_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 stop,
  output logic                 expire,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count
);

  timer_state_e         state_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] reload;

  // A zero length behaves as one cycle.
  assign reload = (len == '0) ? '0 : len - CNT_WIDTH'(1);

  // Retrigger beats expiry, and an empty mask means nothing is left to clear.
  assign expire = (state_q == ACTIVE) && (count_q == '0) && !load && !stop;
  assign busy   = busy_q;
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= ACTIVE;
            count_q <= reload;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (load) begin
            count_q <= reload;
          end else if (stop || count_q == '0) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/q_sys_output_pio_pulse.sv
// Avalon-MM output PIO with set/clear/toggle access and a timed auto-clearing
// pulse mode for driving front-end control strobes.
module q_sys_output_pio_pulse
  import q_sys_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter logic [31:0] RESET_VALUE       = 32'h0,
  parameter int unsigned PULSE_CNT_WIDTH   = 16,
  parameter logic [31:0] DEFAULT_PULSE_LEN = 32'd1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  localparam logic [DATA_WIDTH-1:0]      RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [PULSE_CNT_WIDTH-1:0] RST_LEN  = DEFAULT_PULSE_LEN[PULSE_CNT_WIDTH-1:0];

  logic [DATA_WIDTH-1:0]      data_q, data_wr, data_d;
  logic [DATA_WIDTH-1:0]      active_q, active_wr, active_d;
  logic [PULSE_CNT_WIDTH-1:0] len_q, len_d;
  logic [PULSE_CNT_WIDTH-1:0] timer_count;
  logic [DATA_WIDTH-1:0]      wd;
  logic                       wr, pulse_wr;
  logic                       timer_load, timer_stop, timer_expire, timer_busy;
  logic                       unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Register writes; direct writes take ownership of the bits they touch.
  always_comb begin
    data_wr   = data_q;
    active_wr = active_q;
    len_d     = len_q;
    pulse_wr  = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          data_wr   = wd;
          active_wr = '0;
        end
        ADDR_TOGGLE: begin
          data_wr   = data_q ^ wd;
          active_wr = active_q & ~wd;
        end
        ADDR_PULSE_LEN: len_d = writedata[PULSE_CNT_WIDTH-1:0];
        ADDR_PULSE: begin
          data_wr   = data_q | wd;
          active_wr = active_q | wd;
          pulse_wr  = 1'b1;
        end
        ADDR_SET: begin
          data_wr   = data_q | wd;
          active_wr = active_q & ~wd;
        end
        ADDR_CLEAR: begin
          data_wr   = data_q & ~wd;
          active_wr = active_q & ~wd;
        end
        default: ;
      endcase
    end
  end

  // Expiry only clears bits still owned by the pulse after this cycle's write.
  always_comb begin
    data_d   = data_wr;
    active_d = active_wr;
    if (timer_expire) begin
      data_d   = data_wr & ~active_wr;
      active_d = '0;
    end
  end

  // A zero-mask PULSE only counts as a retrigger once a pulse is running.
  assign timer_load = pulse_wr & ((|wd) | timer_busy);
  assign timer_stop = ~|active_wr;

  q_sys_pio_pulse_timer #(
    .CNT_WIDTH (PULSE_CNT_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .len     (len_q),
    .stop    (timer_stop),
    .expire  (timer_expire),
    .busy    (timer_busy),
    .count   (timer_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RST_DATA;
      active_q <= '0;
      len_q    <= RST_LEN;
    end else begin
      data_q   <= data_d;
      active_q <= active_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PULSE_LEN: readdata[PULSE_CNT_WIDTH-1:0] = len_q;
      ADDR_PULSE:     readdata[DATA_WIDTH-1:0]      = active_q;
      ADDR_STATUS:    readdata[STATUS_BUSY_BIT]     = timer_busy;
      ADDR_COUNT:     readdata[PULSE_CNT_WIDTH-1:0] = timer_count;
      default:        readdata[DATA_WIDTH-1:0]      = data_q;
    endcase
  end

  assign out_port   = data_q;
  assign pulse_busy = timer_busy;

endmodule

// File: tb/tb_q_sys_output_pio_pulse.sv
// Directed bench for the pulse PIO: a register-access vector table followed
// by cycle-accurate pulse, retrigger, ownership and reset sequences.
module tb_q_sys_output_pio_pulse;
  import q_sys_pio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        cs;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  q_sys_output_pio_pulse #(
    .DATA_WIDTH        (8),
    .RESET_VALUE       (32'hA5),
    .PULSE_CNT_WIDTH   (16),
    .DEFAULT_PULSE_LEN (32'd1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Advance one clock edge; bus strobes last exactly one edge.
  task automatic step();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  initial begin
    logic [31:0] r;
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    address      = 3'd0;
    writedata    = 32'h0;

    vecs[0]  = '{1'b1, ADDR_DATA,      32'h3C,    8'h3C, ADDR_DATA,      32'h3C};
    vecs[1]  = '{1'b1, ADDR_DATA,      32'h0F,    8'h0F, ADDR_TOGGLE,    32'h0F};
    vecs[2]  = '{1'b1, ADDR_SET,       32'hF0,    8'hFF, ADDR_SET,       32'hFF};
    vecs[3]  = '{1'b1, ADDR_CLEAR,     32'h81,    8'h7E, ADDR_CLEAR,     32'h7E};
    vecs[4]  = '{1'b1, ADDR_TOGGLE,    32'hFF,    8'h81, ADDR_DATA,      32'h81};
    vecs[5]  = '{1'b0, ADDR_DATA,      32'h55,    8'h81, ADDR_DATA,      32'h81};
    vecs[6]  = '{1'b1, ADDR_DATA,      32'h1FF,   8'hFF, ADDR_DATA,      32'hFF};
    vecs[7]  = '{1'b1, ADDR_PULSE_LEN, 32'h12345, 8'hFF, ADDR_PULSE_LEN, 32'h2345};
    vecs[8]  = '{1'b1, ADDR_PULSE_LEN, 32'h4,     8'hFF, ADDR_PULSE_LEN, 32'h4};
    vecs[9]  = '{1'b1, ADDR_DATA,      32'h0,     8'h00, ADDR_STATUS,    32'h0};
    vecs[10] = '{1'b1, ADDR_PULSE,     32'h0,     8'h00, ADDR_STATUS,    32'h0};

    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    check("reset_out", 32'(out_port), 32'hA5);
    check("reset_busy", 32'(pulse_busy), 32'h0);
    rd(ADDR_STATUS, r);    check("reset_status", r, 32'h0);
    rd(ADDR_PULSE_LEN, r); check("reset_len", r, 32'h1);
    rd(ADDR_DATA, r);      check("reset_data", r, 32'hA5);

    for (int i = 0; i < 11; i++) begin
      chipselect = vecs[i].cs;
      write_n    = 1'b0;
      address    = vecs[i].addr;
      writedata  = vecs[i].wd;
      step();
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
      rd(vecs[i].rd_addr, r);
      check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
    end

    // PULSE_LEN=4: bit0 high for exactly 4 cycles, COUNT 3..0.
    wr(ADDR_PULSE, 32'h01);
    rd(ADDR_PULSE, r); check("p4_active", r, 32'h01);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("p4_out_c%0d", k), 32'(out_port), 32'h01);
      check($sformatf("p4_busy_c%0d", k), 32'(pulse_busy), 32'h1);
      rd(ADDR_COUNT, r); check($sformatf("p4_count_c%0d", k), r, 32'(3 - k));
      step();
    end
    check("p4_out_end", 32'(out_port), 32'h00);
    check("p4_busy_end", 32'(pulse_busy), 32'h0);
    rd(ADDR_PULSE, r); check("p4_active_end", r, 32'h0);

    // PULSE_LEN=0 behaves as a single cycle.
    wr(ADDR_PULSE_LEN, 32'h0);
    wr(ADDR_PULSE, 32'h02);
    check("p0_out_c0", 32'(out_port), 32'h02);
    step();
    check("p0_out_end", 32'(out_port), 32'h00);
    check("p0_busy_end", 32'(pulse_busy), 32'h0);

    // Retrigger three cycles in: both bits clear 5 cycles after the second write.
    wr(ADDR_PULSE_LEN, 32'h5);
    wr(ADDR_PULSE, 32'h01);
    step();
    step();
    wr(ADDR_PULSE, 32'h04);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rt_out_c%0d", k), 32'(out_port), 32'h05);
      step();
    end
    check("rt_out_end", 32'(out_port), 32'h00);
    check("rt_busy_end", 32'(pulse_busy), 32'h0);

    // SET takes ownership of bit0; expiry only clears bit1.
    wr(ADDR_PULSE_LEN, 32'h6);
    wr(ADDR_PULSE, 32'h03);
    step();
    wr(ADDR_SET, 32'h01);
    rd(ADDR_PULSE, r); check("own_active", r, 32'h02);
    for (int k = 2; k < 6; k++) begin
      check($sformatf("own_out_c%0d", k), 32'(out_port), 32'h03);
      step();
    end
    check("own_out_end", 32'(out_port), 32'h01);
    check("own_busy_end", 32'(pulse_busy), 32'h0);

    // DATA write empties the mask: timer stops at once.
    wr(ADDR_DATA, 32'h00);
    wr(ADDR_PULSE, 32'h03);
    step();
    wr(ADDR_DATA, 32'h00);
    check("dstop_out", 32'(out_port), 32'h00);
    check("dstop_busy", 32'(pulse_busy), 32'h0);
    rd(ADDR_COUNT, r); check("dstop_count", r, 32'h0);

    // PULSE write on the expiry edge retriggers instead of clearing.
    wr(ADDR_PULSE_LEN, 32'h2);
    wr(ADDR_PULSE, 32'h01);
    step();
    wr(ADDR_PULSE, 32'h02);
    check("rx_out_c0", 32'(out_port), 32'h03);
    rd(ADDR_COUNT, r); check("rx_count_c0", r, 32'h1);
    step();
    check("rx_out_c1", 32'(out_port), 32'h03);
    step();
    check("rx_out_end", 32'(out_port), 32'h00);

    // SET on the expiry edge keeps its bit while expiry clears the other.
    wr(ADDR_PULSE, 32'h03);
    step();
    wr(ADDR_SET, 32'h01);
    check("sx_out", 32'(out_port), 32'h01);
    check("sx_busy", 32'(pulse_busy), 32'h0);

    // Reset mid-pulse restores everything asynchronously.
    wr(ADDR_PULSE_LEN, 32'd10);
    wr(ADDR_PULSE, 32'hFF);
    repeat (3) step();
    check("rst_pre_busy", 32'(pulse_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_out", 32'(out_port), 32'hA5);
    check("rst_busy", 32'(pulse_busy), 32'h0);
    rd(ADDR_PULSE_LEN, r); check("rst_len", r, 32'h1);
    rd(ADDR_COUNT, r);     check("rst_count", r, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("rst_out_after", 32'(out_port), 32'hA5);
    check("rst_busy_after", 32'(pulse_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
